// File: rtl/int_fp_sched_if.sv
// Bundle of the request, result and converter-side signals of the int-to-float
// scheduler. The slave view belongs to the scheduler; the master view belongs
// to whoever drives the requests, consumes the results and models the converter.
interface int_fp_sched_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]    req_valid_i;
  logic [N-1:0]    req_ready_o;
  logic [N*32-1:0] req_data_i;
  logic            res_valid_o;
  logic            res_ready_i;
  logic [31:0]     res_data_o;
  logic [IDW-1:0]  res_id_o;
  logic            conv_en_o;
  logic [31:0]     conv_data_o;
  logic [31:0]     conv_res_i;
  logic            busy_o;

  modport slave (
    input  req_valid_i, req_data_i, res_ready_i, conv_res_i,
    output req_ready_o, res_valid_o, res_data_o, res_id_o,
           conv_en_o, conv_data_o, busy_o
  );

  modport master (
    output req_valid_i, req_data_i, res_ready_i, conv_res_i,
    input  req_ready_o, res_valid_o, res_data_o, res_id_o,
           conv_en_o, conv_data_o, busy_o
  );
endinterface

// File: rtl/int_fp_sched.sv
// Round-robin scheduler sharing one fixed-latency int-to-float converter
// between N requesters. A granted integer is held on the converter input for
// CONV_LAT cycles with the enable high, the result is then captured and
// offered on the result port together with the owning requester's ID.
module int_fp_sched #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int CONV_LAT = 44
) (
  input  logic          clk_i,
  input  logic          rst_i,
  int_fp_sched_if.slave bus
);

  localparam int CW = $clog2(CONV_LAT) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    OUT
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    conv_data_q, conv_data_d;
  logic [31:0]    res_data_q, res_data_d;
  logic           conv_en_q, conv_en_d;
  logic           res_valid_q, res_valid_d;
  logic           busy_q, busy_d;

  logic           grant_vld;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand;
  logic [N-1:0]   req_ready;

  // Round-robin search starting just after the last served requester; the
  // scan runs from the farthest offset down so the nearest valid one wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int off = N; off >= 1; off--) begin
      cand = IDW'((int'(rr_ptr_q) + off) % N);
      if (bus.req_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Accept strobe is combinational in IDLE and suppressed while reset is
  // asserted, since a grant in that cycle would never be honoured.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_vld && !rst_i) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Next-state and next-output computation for the IDLE/RUN/OUT sequence.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    res_id_d    = res_id_q;
    cnt_d       = cnt_q;
    conv_data_d = conv_data_q;
    res_data_d  = res_data_q;
    conv_en_d   = conv_en_q;
    res_valid_d = res_valid_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          conv_data_d = bus.req_data_i[32*grant_idx +: 32];
          id_d        = grant_idx;
          rr_ptr_d    = grant_idx;
          cnt_d       = '0;
          conv_en_d   = 1'b1;
          busy_d      = 1'b1;
          state_d     = RUN;
        end
      end

      RUN: begin
        if (cnt_q == CW'(CONV_LAT - 1)) begin
          res_data_d  = bus.conv_res_i;
          res_id_d    = id_q;
          conv_en_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = OUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      OUT: begin
        if (bus.res_ready_i) begin
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        conv_en_d   = 1'b0;
        res_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any job in flight and points
  // the round-robin pointer at the last requester so requester 0 goes first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IDW'(N - 1);
      id_q        <= '0;
      res_id_q    <= '0;
      cnt_q       <= '0;
      conv_data_q <= '0;
      res_data_q  <= '0;
      conv_en_q   <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      res_id_q    <= res_id_d;
      cnt_q       <= cnt_d;
      conv_data_q <= conv_data_d;
      res_data_q  <= res_data_d;
      conv_en_q   <= conv_en_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready_o = req_ready;
  assign bus.conv_en_o   = conv_en_q;
  assign bus.conv_data_o = conv_data_q;
  assign bus.res_valid_o = res_valid_q;
  assign bus.res_data_o  = res_data_q;
  assign bus.res_id_o    = res_id_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_int_fp_sched.sv
// Self-checking bench for int_fp_sched: converter model, a timeline-based
// reference model checked every cycle, and directed scenarios with
// hand-computed expectations.
module tb_int_fp_sched;

  localparam int N        = 4;
  localparam int IDW      = 2;
  localparam int CONV_LAT = 44;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  int_fp_sched_if #(.N(N), .IDW(IDW)) bus();

  int_fp_sched #(.N(N), .IDW(IDW), .CONV_LAT(CONV_LAT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Reference int32 -> IEEE-754 single conversion, round to nearest even.
  function automatic logic [31:0] i2f(input logic [31:0] v);
    logic        s;
    logic [31:0] a, m, rem, half;
    int          p, sh;
    if (v == 32'd0) return 32'd0;
    s = v[31];
    a = s ? (~v + 32'd1) : v;
    p = 31;
    while (!a[p]) p--;
    if (p <= 23) begin
      m = a << (23 - p);
    end else begin
      sh   = p - 23;
      m    = a >> sh;
      rem  = a & ((32'd1 << sh) - 32'd1);
      half = 32'd1 << (sh - 1);
      if (rem > half || (rem == half && m[0])) m = m + 32'd1;
      if (m[24]) begin
        m = m >> 1;
        p++;
      end
    end
    return {s, 8'(p + 127), m[22:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [IDW-1:0] k, input logic [31:0] d, input logic v);
    bus.req_data_i[32*k +: 32] = d;
    bus.req_valid_i[k]         = v;
  endtask

  // Converter model: result only becomes correct once enable has been high
  // for CONV_LAT cycles; a low enable clears its progress.
  int en_cnt = 0;
  always @(posedge clk) begin
    if (bus.conv_en_o !== 1'b1) en_cnt <= 0;
    else if (en_cnt < 1000)     en_cnt <= en_cnt + 1;
  end
  assign bus.conv_res_i = (bus.conv_en_o === 1'b1 && en_cnt >= CONV_LAT - 1)
                          ? i2f(bus.conv_data_o) : 32'hDEADBEEF;

  // Reference model: a job accepted at the end of cycle acc has enable in
  // cycles acc+1..acc+CONV_LAT and a valid result from acc+CONV_LAT+1 until
  // handshaken; grants follow round-robin order after the last served index.
  bit             armed    = 1'b0;
  bit             have_job = 1'b0;
  int             acc      = 0;
  int             last_srv = N - 1;
  logic [IDW-1:0] job_id   = '0;
  logic [31:0]    job_data = '0;

  always @(negedge clk) begin
    logic [N-1:0] v;
    logic [N-1:0] exp_ready;
    int           g;
    int           kk;
    bit           exp_en, exp_rv, exp_busy;
    v = bus.req_valid_i;
    g = -1;
    for (int off = 1; off <= N; off++) begin
      kk = (last_srv + off) % N;
      if (g < 0 && v[kk[IDW-1:0]] === 1'b1) g = kk;
    end
    exp_ready = '0;
    if (!have_job && rst !== 1'b1 && g >= 0) exp_ready[g[IDW-1:0]] = 1'b1;
    exp_en   = have_job && cyc >= acc + 1 && cyc <= acc + CONV_LAT;
    exp_rv   = have_job && cyc >= acc + CONV_LAT + 1;
    exp_busy = have_job && cyc >= acc + 1;

    if (armed) begin
      checkOutput("model_req_ready", 32'(bus.req_ready_o), 32'(exp_ready));
      checkOutput("model_conv_en",   32'(bus.conv_en_o),   32'(exp_en));
      checkOutput("model_res_valid", 32'(bus.res_valid_o), 32'(exp_rv));
      checkOutput("model_busy",      32'(bus.busy_o),      32'(exp_busy));
      if (exp_en) checkOutput("model_conv_data", bus.conv_data_o, job_data);
      if (exp_rv) begin
        checkOutput("model_res_data", bus.res_data_o, i2f(job_data));
        checkOutput("model_res_id",   32'(bus.res_id_o), 32'(job_id));
      end
    end

    if (rst === 1'b1) begin
      armed    = 1'b1;
      have_job = 1'b0;
      last_srv = N - 1;
    end else if (!have_job && g >= 0) begin
      have_job = 1'b1;
      job_id   = g[IDW-1:0];
      job_data = bus.req_data_i[32*g +: 32];
      acc      = cyc;
      last_srv = g;
    end else if (exp_rv && bus.res_ready_i === 1'b1) begin
      have_job = 1'b0;
    end
  end

  task automatic waitAccept(output int c);
    bit ok;
    ok = 1'b0;
    c  = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((bus.req_ready_o & bus.req_valid_i) != '0) begin
        c  = cyc;
        ok = 1'b1;
        break;
      end
    end
    checkOutput("accept_seen", 32'(ok), 32'd1);
  endtask

  task automatic waitResult(input logic [31:0] exp_conv, output int c, output logic [31:0] d,
                            output logic [IDW-1:0] id, output int ens, output int rdys,
                            output bit conv_ok);
    bit ok;
    ok = 1'b0; c = 0; d = '0; id = '0; ens = 0; rdys = 0; conv_ok = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.req_ready_o != '0) rdys++;
      if (bus.res_valid_o === 1'b1) begin
        c  = cyc;
        d  = bus.res_data_o;
        id = bus.res_id_o;
        ok = 1'b1;
        break;
      end
      if (bus.conv_en_o === 1'b1) begin
        ens++;
        if (bus.conv_data_o !== exp_conv) conv_ok = 1'b0;
      end
    end
    checkOutput("result_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int             a, c, ens, rdys;
    logic [31:0]    d;
    logic [IDW-1:0] id;
    bit             cok;
    int             rc[5];
    logic [31:0]    exp_data[5];
    logic [IDW-1:0] exp_id[5];

    rst             = 1'b1;
    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
    bus.res_ready_i = 1'b1;

    // Pin the reference conversion to known encodings.
    checkOutput("i2f_5",       i2f(32'd5),        32'h40A00000);
    checkOutput("i2f_m1",      i2f(32'hFFFFFFFF), 32'hBF800000);
    checkOutput("i2f_4",       i2f(32'd4),        32'h40800000);
    checkOutput("i2f_max",     i2f(32'h7FFFFFFF), 32'h4F000000);
    checkOutput("i2f_min",     i2f(32'h80000000), 32'hCF000000);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(bus.req_ready_o), 32'd0);
    checkOutput("rst_res_valid", 32'(bus.res_valid_o), 32'd0);
    checkOutput("rst_res_data",  bus.res_data_o,       32'd0);
    checkOutput("rst_res_id",    32'(bus.res_id_o),    32'd0);
    checkOutput("rst_conv_en",   32'(bus.conv_en_o),   32'd0);
    checkOutput("rst_conv_data", bus.conv_data_o,      32'd0);
    checkOutput("rst_busy",      32'(bus.busy_o),      32'd0);

    // Single request from requester 0.
    $display("[TB] single request");
    @(posedge clk); #1;
    applyStimulus(2'd0, 32'd5, 1'b1);
    waitAccept(a);
    @(posedge clk); #1;
    applyStimulus(2'd0, 32'd5, 1'b0);
    waitResult(32'd5, c, d, id, ens, rdys, cok);
    checkOutput("t1_en_cycles", 32'(ens),     32'd44);
    checkOutput("t1_latency",   32'(c - a),   32'd45);
    checkOutput("t1_data",      d,            32'h40A00000);
    checkOutput("t1_id",        32'(id),      32'd0);
    checkOutput("t1_ready_once",32'(rdys),    32'd0);
    checkOutput("t1_conv_data", 32'(cok),     32'd1);

    // Negative value and ID mapping through requester 2.
    $display("[TB] negative / id mapping");
    @(posedge clk); #1;
    applyStimulus(2'd2, 32'hFFFFFFFF, 1'b1);
    waitAccept(a);
    @(posedge clk); #1;
    applyStimulus(2'd2, 32'hFFFFFFFF, 1'b0);
    waitResult(32'hFFFFFFFF, c, d, id, ens, rdys, cok);
    checkOutput("t2_data",      d,         32'hBF800000);
    checkOutput("t2_id",        32'(id),   32'd2);
    checkOutput("t2_conv_data", 32'(cok),  32'd1);
    checkOutput("t2_en_cycles", 32'(ens),  32'd44);

    // Arbitration from a fresh reset with all four requesters active.
    $display("[TB] arbitration");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < N; k++) applyStimulus(k[IDW-1:0], 32'(k + 1), 1'b1);
    exp_id   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_data = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h3F800000};
    for (int r = 0; r < 5; r++) begin
      waitResult(32'd0, rc[r], d, id, ens, rdys, cok);
      checkOutput("t3_id",      32'(id),   32'(exp_id[r]));
      checkOutput("t3_data",    d,         exp_data[r]);
      checkOutput("t3_accepts", 32'(rdys), 32'd1);
    end
    checkOutput("t3_period_a", 32'(rc[1] - rc[0]), 32'd46);
    checkOutput("t3_period_b", 32'(rc[4] - rc[3]), 32'd46);
    @(posedge clk); #1;
    bus.req_valid_i = '0;

    // Backpressure: result held for 10 cycles, accepted on the 11th.
    $display("[TB] backpressure");
    bus.res_ready_i = 1'b0;
    applyStimulus(2'd1, 32'd7, 1'b1);
    waitAccept(a);
    @(posedge clk); #1;
    applyStimulus(2'd1, 32'd7, 1'b0);
    applyStimulus(2'd3, 32'd9, 1'b1);
    waitResult(32'd7, c, d, id, ens, rdys, cok);
    checkOutput("t4_data", d,         32'h40E00000);
    checkOutput("t4_id",   32'(id),   32'd1);
    checkOutput("t4_rdys", 32'(rdys), 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("t4_hold_valid", 32'(bus.res_valid_o), 32'd1);
      checkOutput("t4_hold_data",  bus.res_data_o,       32'h40E00000);
      checkOutput("t4_hold_en",    32'(bus.conv_en_o),   32'd0);
      checkOutput("t4_hold_ready", 32'(bus.req_ready_o), 32'd0);
      checkOutput("t4_hold_busy",  32'(bus.busy_o),      32'd1);
    end
    @(posedge clk); #1 bus.res_ready_i = 1'b1;
    @(negedge clk);
    checkOutput("t4_last_valid", 32'(bus.res_valid_o), 32'd1);
    @(negedge clk);
    checkOutput("t4_idle_busy",  32'(bus.busy_o),      32'd0);
    checkOutput("t4_idle_valid", 32'(bus.res_valid_o), 32'd0);
    checkOutput("t4_idle_grant", 32'(bus.req_ready_o), 32'h8);
    @(posedge clk); #1;
    applyStimulus(2'd3, 32'd9, 1'b0);
    waitResult(32'd9, c, d, id, ens, rdys, cok);
    checkOutput("t4_next_data", d,       32'h41100000);
    checkOutput("t4_next_id",   32'(id), 32'd3);

    // Reset in the middle of RUN, then a fresh job from requester 1.
    $display("[TB] reset mid-run");
    @(posedge clk); #1;
    applyStimulus(2'd0, 32'd3, 1'b1);
    waitAccept(a);
    @(posedge clk); #1;
    applyStimulus(2'd0, 32'd3, 1'b0);
    repeat (20) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("t5_en",    32'(bus.conv_en_o),   32'd0);
    checkOutput("t5_valid", 32'(bus.res_valid_o), 32'd0);
    checkOutput("t5_busy",  32'(bus.busy_o),      32'd0);
    @(posedge clk); #1;
    applyStimulus(2'd1, 32'd1, 1'b1);
    waitAccept(a);
    @(posedge clk); #1;
    applyStimulus(2'd1, 32'd1, 1'b0);
    waitResult(32'd1, c, d, id, ens, rdys, cok);
    checkOutput("t5_latency", 32'(c - a), 32'd45);
    checkOutput("t5_data",    d,          32'h3F800000);
    checkOutput("t5_id",      32'(id),    32'd1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
